// File: rtl/btn_reader.sv
// ---------------------------------------------------------------------------
// btn_reader -- eight-channel pushbutton debouncer with press/release events
//
// Each raw button bit is brought into the clock domain by a two-flop
// synchronizer. A per-channel stability counter then debounces it. The
// debounced level toggles after the synchronized bit has disagreed with it
// for DEB_CYCLES consecutive edges. Toggles produce registered one-cycle
// press/release pulses. A running press counter and a "last pressed channel"
// register are derived from the press pulses.
//
// Optional feature macro: BTN_READER_RELEASE_EVT_EN
//   defined   : release_pulse is generated and releases assert any_evt
//   undefined : release_pulse is tied to 8'h00; only presses assert any_evt
//
// Parameters
//   DEB_CYCLES    consecutive stable cycles needed to accept a change (2..255)
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   btn_in[7:0]   raw asynchronous active-high buttons
//   db_level[7:0] debounced level per channel
//   press_pulse   one-cycle pulse per channel on an accepted 0->1
//   release_pulse one-cycle pulse per channel on an accepted 1->0
//   press_count   running count of accepted presses, modulo 256
//   last_btn      lowest index in the most recent non-zero press_pulse
//   any_evt       high in the same cycle as any press/release pulse
// ---------------------------------------------------------------------------
module btn_reader #(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn_in,
    output logic [7:0] db_level,
    output logic [7:0] press_pulse,
    output logic [7:0] release_pulse,
    output logic [7:0] press_count,
    output logic [2:0] last_btn,
    output logic       any_evt
);

    // A channel is accepted on the edge where its counter already holds
    // DEB_CYCLES-1 and the bit still differs. That edge is the
    // DEB_CYCLES-th consecutive differing edge.
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic [7:0] sync1_q, sync2_q;
    logic [7:0] cnt_q [8];
    logic [7:0] cnt_d [8];
    logic [7:0] db_q,      db_d;
    logic [7:0] press_q,   press_d;
    logic [7:0] release_q, release_d;
    logic [7:0] count_q,   count_d;
    logic [2:0] last_q,    last_d;
    logic       any_q,     any_d;
    logic [7:0] toggle;
    logic [7:0] pop;
    logic [2:0] low_idx;

    always_comb begin
        toggle = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == DEB_LAST) begin
                cnt_d[i]  = 8'd0;
                toggle[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end

        db_d    = db_q ^ toggle;
        press_d = toggle & ~db_q;
`ifdef BTN_READER_RELEASE_EVT_EN
        release_d = toggle & db_q;
`else
        release_d = 8'h00;
`endif
        // Computed from the next-state pulses so any_evt lands in the
        // same cycle as the pulses it reports.
        any_d = (|press_d) | (|release_d);

        // Count and last-index are derived from the registered pulses,
        // so they update on the edge after the pulse is visible.
        pop     = 8'd0;
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            pop = pop + {7'd0, press_q[i]};
            if (press_q[i]) begin
                low_idx = 3'(i);
            end
        end
        count_d = count_q + pop;
        last_d  = (press_q != 8'h00) ? low_idx : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 8'h00;
            sync2_q   <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= 8'd0;
            end
            db_q      <= 8'h00;
            press_q   <= 8'h00;
            release_q <= 8'h00;
            count_q   <= 8'd0;
            last_q    <= 3'd0;
            any_q     <= 1'b0;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
            last_q    <= last_d;
            any_q     <= any_d;
        end
    end

    assign db_level      = db_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign press_count   = count_q;
    assign last_btn      = last_q;
    assign any_evt       = any_q;

endmodule

// File: tb/tb_btn_reader.sv
// ---------------------------------------------------------------------------
// tb_btn_reader -- self-checking bench for btn_reader with DEB_CYCLES=4.
// Each expected event word {edge, release_pulse, press_pulse, any_evt} is
// queued when stimulus is driven. A negedge monitor pops and compares an
// entry whenever the DUT shows an event. Levels, counts and last_btn are
// checked against a small behavioural model after every input change.
// ---------------------------------------------------------------------------
module tb_btn_reader;
    localparam int DEB = 4;
    localparam int W   = 33;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] btn_in = 8'h00;
    logic [7:0] db_level, press_pulse, release_pulse, press_count;
    logic [2:0] last_btn;
    logic       any_evt;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    btn_reader #(.DEB_CYCLES(DEB)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .db_level      (db_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_count   (press_count),
        .last_btn      (last_btn),
        .any_evt       (any_evt)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0] m_db    = 8'h00;
    logic [7:0] m_count = 8'h00;
    logic [2:0] m_last  = 3'd0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (press_pulse != 8'h00 || release_pulse != 8'h00 || any_evt) begin
            if (exp_q.size() == 0) begin
                check_val("evt_unexpected", {cyc[15:0], release_pulse, press_pulse, any_evt}, 64'h0);
            end else begin
                check_val("evt", {cyc[15:0], release_pulse, press_pulse, any_evt}, exp_q.pop_front());
            end
        end
    end

    function automatic logic [7:0] popcnt(input logic [7:0] v);
        logic [7:0] n = 8'd0;
        for (int i = 0; i < 8; i++) n = n + {7'd0, v[i]};
        return n;
    endfunction

    // driver: change btn_in, queue the expected event, let it settle, check
    task automatic btn_change(input logic [7:0] v);
        logic [7:0] p, r;
        int unsigned c;
        @(posedge clk); #1;
        btn_in = v;
        c = cyc;
        p = v & ~m_db;
`ifdef BTN_READER_RELEASE_EVT_EN
        r = ~v & m_db;
`else
        r = 8'h00;
`endif
        if (p != 8'h00 || r != 8'h00)
            exp_q.push_back({16'(c + DEB + 2), r, p, 1'b1});
        m_db    = v;
        m_count = m_count + popcnt(p);
        for (int i = 7; i >= 0; i--) if (p[i]) m_last = 3'(i);
        repeat (DEB + 3) @(posedge clk);
        @(negedge clk);
        check_val("db_level", db_level, m_db);
        check_val("press_count", press_count, m_count);
        check_val("last_btn", last_btn, m_last);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_db"}, db_level, 0);
        check_val({tag, "_press"}, press_pulse, 0);
        check_val({tag, "_rel"}, release_pulse, 0);
        check_val({tag, "_count"}, press_count, 0);
        check_val({tag, "_last"}, last_btn, 0);
        check_val({tag, "_any"}, any_evt, 0);
    endtask

    initial begin
        int unsigned r0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // single press on channel 0: pulse on edge 6, count/last one later
        btn_change(8'h01);

        // glitch on channel 3 lasting three cycles
        @(posedge clk); #1;
        btn_in = 8'h09;
        repeat (3) @(posedge clk);
        #1;
        btn_in = 8'h01;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_val("glitch_db", db_level, 8'h01);
        check_val("glitch_count", press_count, 8'd1);

        // simultaneous presses on channels 2 and 7
        btn_change(8'h00);
        btn_change(8'h84);
        check_val("multi_last", last_btn, 3'd2);

        // press then release channel 5
        btn_change(8'h20);
        btn_change(8'h00);

        // reset in the middle of a debounce with channel 1 held
        @(posedge clk); #1;
        btn_in = 8'h02;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        r0 = cyc;
        m_db = 8'h00; m_count = 8'd0; m_last = 3'd0;
        @(negedge clk);
        check_all_zero("mid_rst");
        exp_q.push_back({16'(r0 + DEB + 2), 8'h00, 8'h02, 1'b1});
        m_db = 8'h02; m_count = 8'd1; m_last = 3'd1;
        repeat (DEB + 3) @(posedge clk);
        @(negedge clk);
        check_val("rst_press_count", press_count, 8'd1);
        check_val("rst_last", last_btn, 3'd1);

        // random patterns
        for (int k = 0; k < 8; k++) btn_change(8'($urandom_range(0, 255)));

        // drive the counter to 255, then wrap it
        btn_change(8'h00);
        while (m_count <= 8'd247) begin
            btn_change(8'hFF);
            btn_change(8'h00);
        end
        while (m_count != 8'd255) begin
            btn_change(8'h01);
            btn_change(8'h00);
        end
        check_val("count_255", press_count, 8'd255);
        btn_change(8'h10);
        check_val("count_wrap", press_count, 8'd0);
        check_val("wrap_last", last_btn, 3'd4);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
